qft3_measure_unit: RTL

- Downstream consumer of the 3-qubit QFT pipeline output vector.
- Captures one 8-amplitude complex state vector (f000..f111) and computes the Born probability |a|^2 = re^2 + im^2 for each basis state, using one shared multiplier pair (sequential).
- Streams the 8 probabilities out over a valid/ready interface.
- Reports the argmax basis index, its probability, and the total probability (normalisation check).

---
 rtl/qft3_measure_unit_if.sv | 33 +++
 rtl/qft3_measure_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/qft3_measure_unit_if.sv
// Valid/ready bundle between the QFT pipeline, the measurement unit and its consumer.
// The master drives vectors and out_ready; the slave (the unit) returns beats and results.
interface qft3_measure_unit_if #(
  parameter int DATA_W = 8,
  parameter int PROB_W = 2*DATA_W,
  parameter int SUM_W  = 2*DATA_W+3
);
  logic                in_valid;
  logic                in_ready;
  logic [8*DATA_W-1:0] in_r;
  logic [8*DATA_W-1:0] in_i;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          out_idx;
  logic [PROB_W-1:0]   out_prob;
  logic                out_last;
  logic                res_valid;
  logic [2:0]          argmax_idx;
  logic [PROB_W-1:0]   argmax_prob;
  logic [SUM_W-1:0]    prob_sum;

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_idx, out_prob, out_last,
           res_valid, argmax_idx, argmax_prob, prob_sum
  );

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_idx, out_prob, out_last,
           res_valid, argmax_idx, argmax_prob, prob_sum
  );
endinterface

// File: rtl/qft3_measure_unit.sv
// Born-probability measurement of a captured 3-qubit state vector: one shared squarer
// pair, a registered product stage, then argmax/sum and an 8-beat probability stream.
module qft3_measure_unit #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int PROB_W = 2*DATA_W,
  parameter int SUM_W  = 2*DATA_W+3
) (
  input  logic               clk,
  input  logic               rst_n,
  qft3_measure_unit_if.slave bus
);

  if (FRAC_W >= DATA_W) begin : g_bad_frac_w
    $error("FRAC_W must leave at least one integer bit in DATA_W");
  end

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_e;

  state_e                   state_q;
  logic signed [DATA_W-1:0] re_q   [8];
  logic signed [DATA_W-1:0] im_q   [8];
  logic        [PROB_W-1:0] prob_q [8];

  // k_q issues operands 0..7; value 8 means every basis state has been issued.
  logic [3:0]        k_q;
  logic [PROB_W-1:0] sq_q;
  logic [2:0]        sq_idx_q;
  logic              sq_vld_q;

  logic [SUM_W-1:0]  sum_q;
  logic [PROB_W-1:0] max_q;
  logic [2:0]        max_idx_q;

  logic              in_ready_q;
  logic              out_valid_q;
  logic [2:0]        out_idx_q;
  logic [PROB_W-1:0] out_prob_q;
  logic              out_last_q;
  logic              res_valid_q;
  logic [2:0]        argmax_idx_q;
  logic [PROB_W-1:0] argmax_prob_q;
  logic [SUM_W-1:0]  prob_sum_q;

  logic signed [DATA_W-1:0]   re_op;
  logic signed [DATA_W-1:0]   im_op;
  logic signed [2*DATA_W-1:0] re_sq;
  logic signed [2*DATA_W-1:0] im_sq;
  logic        [PROB_W-1:0]   sq_d;
  logic                       take_new;
  logic        [PROB_W-1:0]   max_d;
  logic        [2:0]          max_idx_d;
  logic        [SUM_W-1:0]    sum_d;

  // Squares are non-negative, so (-2^(DATA_W-1))^2 still fits the signed product width.
  always_comb begin
    re_op = re_q[k_q[2:0]];
    im_op = im_q[k_q[2:0]];
    re_sq = re_op * re_op;
    im_sq = im_op * im_op;
    sq_d  = PROB_W'($unsigned(re_sq)) + PROB_W'($unsigned(im_sq));
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    take_new  = (sq_idx_q == 3'd0) || (sq_q > max_q);
    max_d     = take_new ? sq_q : max_q;
    max_idx_d = take_new ? sq_idx_q : max_idx_q;
    sum_d     = sum_q + SUM_W'(sq_q);
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      // NOTE: the operand and probability arrays are reset so an aborted vector leaves no residue.
      for (int k = 0; k < 8; k++) begin
        re_q[k]   <= '0;
        im_q[k]   <= '0;
        prob_q[k] <= '0;
      end
      k_q           <= '0;
      sq_q          <= '0;
      sq_idx_q      <= '0;
      sq_vld_q      <= 1'b0;
      sum_q         <= '0;
      max_q         <= '0;
      max_idx_q     <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_idx_q     <= '0;
      out_prob_q    <= '0;
      out_last_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      argmax_idx_q  <= '0;
      argmax_prob_q <= '0;
      prob_sum_q    <= '0;
    end else begin
      res_valid_q <= 1'b0;
      sq_vld_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            for (int k = 0; k < 8; k++) begin
              re_q[k] <= bus.in_r[k*DATA_W +: DATA_W];
              im_q[k] <= bus.in_i[k*DATA_W +: DATA_W];
            end
            sum_q      <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end

        CALC: begin
          if (k_q != 4'd8) begin
            sq_q     <= sq_d;
            sq_idx_q <= k_q[2:0];
            sq_vld_q <= 1'b1;
            k_q      <= k_q + 4'd1;
          end
          // Second stage retires the product issued one cycle earlier.
          if (sq_vld_q) begin
            prob_q[sq_idx_q] <= sq_q;
            sum_q            <= sum_d;
            max_q            <= max_d;
            max_idx_q        <= max_idx_d;
            if (sq_idx_q == 3'd7) begin
              argmax_idx_q  <= max_idx_d;
              argmax_prob_q <= max_d;
              prob_sum_q    <= sum_d;
              res_valid_q   <= 1'b1;
              out_valid_q   <= 1'b1;
              out_idx_q     <= 3'd0;
              out_prob_q    <= prob_q[0];
              out_last_q    <= 1'b0;
              state_q       <= EMIT;
            end
          end
        end

        EMIT: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_idx_q   <= '0;
              out_prob_q  <= '0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end else begin
              out_idx_q  <= out_idx_q + 3'd1;
              out_prob_q <= prob_q[out_idx_q + 3'd1];
              out_last_q <= (out_idx_q == 3'd6);
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.out_prob    = out_prob_q;
  assign bus.out_last    = out_last_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.argmax_idx  = argmax_idx_q;
  assign bus.argmax_prob = argmax_prob_q;
  assign bus.prob_sum    = prob_sum_q;

endmodule
